// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// data_mem_ctrl_if : request/response bus of the MEM-stage data memory
// Revision 1.0
// ============================================================================
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// data_mem_ctrl : byte-addressed data memory with wait states and error flags
// Revision 1.0
// ============================================================================
module data_mem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_ctrl_if.slave   bus
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              write_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              err_w;
  logic [31:0]       word;
  logic [7:0]        byte_w;
  logic [15:0]       half_w;
  logic [31:0]       load_val;
  logic [3:0]        be;
  logic [31:0]       wrep;

  assign bus.req_ready  = (state_q == S_IDLE) && !reset;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && bus.req_ready;
  assign idx    = addr_q[IDX_W+1:2];
  assign lane   = addr_q[1:0];
  assign word   = mem[idx];

  always_comb begin
    err_w = 1'b0;
    case (size_q)
      2'b00:   err_w = 1'b0;
      2'b01:   err_w = addr_q[0];
      2'b10:   err_w = |addr_q[1:0];
      default: err_w = 1'b1;
    endcase
    // Any address bit above the array's word index means out of range
    if (|addr_q[ADDR_W-1:IDX_W+2]) begin
      err_w = 1'b1;
    end
  end

  always_comb begin
    byte_w   = word[{lane, 3'b000} +: 8];
    half_w   = addr_q[1] ? word[31:16] : word[15:0];
    load_val = '0;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_w[7]}}, byte_w};
      2'b01:   load_val = {{16{signed_q & half_w[15]}}, half_w};
      2'b10:   load_val = word;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    be   = 4'b0000;
    wrep = wdata_q;
    case (size_q)
      2'b00: begin
        be   = 4'b0001 << lane;
        wrep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array has no reset; an async reset drops state_q out of ACCESS, cancelling the commit
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && write_q && !err_w) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wrep[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = 4'(WAIT_LOAD);
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        err_d   = err_w;
        rdata_d = (write_q || err_w) ? 32'd0 : load_val;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      write_q  <= bus.req_write;
      signed_q <= bus.req_signed;
      size_q   <= bus.req_size;
      addr_q   <= bus.req_addr;
      wdata_q  <= bus.req_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_data_mem_ctrl : directed vectors for data_mem_ctrl at WAIT_CYCLES 0/1/15
// Revision 1.0
// ============================================================================
module tb_data_mem_ctrl;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  vld;
  logic        wr;
  logic [1:0]  sz;
  logic        sg;
  logic [31:0] ad;
  logic [31:0] wd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=1, 2: WAIT_CYCLES=15
  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus0 ();
  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();
  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus2 ();

  assign bus0.req_valid = vld[0];
  assign bus1.req_valid = vld[1];
  assign bus2.req_valid = vld[2];
  assign bus0.req_write = wr;  assign bus1.req_write = wr;  assign bus2.req_write = wr;
  assign bus0.req_size  = sz;  assign bus1.req_size  = sz;  assign bus2.req_size  = sz;
  assign bus0.req_signed = sg; assign bus1.req_signed = sg; assign bus2.req_signed = sg;
  assign bus0.req_addr  = ad;  assign bus1.req_addr  = ad;  assign bus2.req_addr  = ad;
  assign bus0.req_wdata = wd;  assign bus1.req_wdata = wd;  assign bus2.req_wdata = wd;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(0))  u_w0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(1))  u_w1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  function automatic logic f_rdy(input int s);
    case (s)
      0:       return bus0.req_ready;
      1:       return bus1.req_ready;
      default: return bus2.req_ready;
    endcase
  endfunction

  function automatic logic f_rv(input int s);
    case (s)
      0:       return bus0.resp_valid;
      1:       return bus1.resp_valid;
      default: return bus2.resp_valid;
    endcase
  endfunction

  function automatic logic f_err(input int s);
    case (s)
      0:       return bus0.resp_err;
      1:       return bus1.resp_err;
      default: return bus2.resp_err;
    endcase
  endfunction

  function automatic logic [31:0] f_rd(input int s);
    case (s)
      0:       return bus0.resp_rdata;
      1:       return bus1.resp_rdata;
      default: return bus2.resp_rdata;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: got timeout expected response", nm);
  endtask

  // Called at a negedge. Latency counts negedges after the cycle in which
  // valid&&ready was seen, up to the first one showing resp_valid.
  task automatic xact(input int s, input logic w, input logic [1:0] z, input logic g,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    int busy_rdy;
    wr = w; sz = z; sg = g; ad = a; wd = d;
    vld[s] = 1'b1;
    n = 0;
    while (!f_rdy(s) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!f_rdy(s)) fail_now("accept");
    @(posedge clk);
    #1 vld[s] = 1'b0;
    lat = 0; busy_rdy = 0; rd = '0; er = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (f_rdy(s)) busy_rdy++;
    end while (!f_rv(s) && lat < 40);
    if (!f_rv(s)) fail_now("resp_valid");
    rd = f_rd(s);
    er = f_err(s);
    chk("ready while busy", busy_rdy, 0);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  z;
    logic        g;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tv [26];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nrv;

    tv[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0};
    tv[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b1, 2'b00, 1'b0, 32'h11,       32'h00000080, 32'h00000000, 1'b0};
    tv[3]  = '{1'b0, 2'b00, 1'b1, 32'h11,       32'h0,        32'hFFFFFF80, 1'b0};
    tv[4]  = '{1'b0, 2'b00, 1'b0, 32'h11,       32'h0,        32'h00000080, 1'b0};
    tv[5]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hDEAD80EF, 1'b0};
    tv[6]  = '{1'b1, 2'b01, 1'b0, 32'h12,       32'h00001234, 32'h00000000, 1'b0};
    tv[7]  = '{1'b0, 2'b01, 1'b0, 32'h12,       32'h0,        32'h00001234, 1'b0};
    tv[8]  = '{1'b0, 2'b10, 1'b0, 32'h13,       32'h0,        32'h00000000, 1'b1};
    tv[9]  = '{1'b0, 2'b01, 1'b0, 32'h11,       32'h0,        32'h00000000, 1'b1};
    tv[10] = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'h123480EF, 1'b0};
    tv[11] = '{1'b0, 2'b01, 1'b1, 32'h10,       32'h0,        32'hFFFF80EF, 1'b0};
    tv[12] = '{1'b0, 2'b00, 1'b1, 32'h13,       32'h0,        32'h00000012, 1'b0};
    tv[13] = '{1'b1, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 32'h00000000, 1'b0};
    tv[14] = '{1'b1, 2'b10, 1'b0, 32'h400,      32'h11111111, 32'h00000000, 1'b1};
    tv[15] = '{1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
    tv[16] = '{1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        32'h00000000, 1'b1};
    tv[17] = '{1'b1, 2'b11, 1'b0, 32'h0,        32'h77777777, 32'h00000000, 1'b1};
    tv[18] = '{1'b1, 2'b01, 1'b0, 32'h1,        32'h0000BEEF, 32'h00000000, 1'b1};
    tv[19] = '{1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        32'hCAFEF00D, 1'b0};
    tv[20] = '{1'b0, 2'b10, 1'b0, 32'h80000000, 32'h0,        32'h00000000, 1'b1};
    tv[21] = '{1'b1, 2'b00, 1'b0, 32'h3,        32'hFFFFFFAB, 32'h00000000, 1'b0};
    tv[22] = '{1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        32'hABFEF00D, 1'b0};
    tv[23] = '{1'b0, 2'b00, 1'b0, 32'h3,        32'h0,        32'h000000AB, 1'b0};
    tv[24] = '{1'b0, 2'b01, 1'b1, 32'h2,        32'h0,        32'hFFFFABFE, 1'b0};
    tv[25] = '{1'b0, 2'b01, 1'b0, 32'h2,        32'h0,        32'h0000ABFE, 1'b0};

    vld = 3'b000; wr = 1'b0; sz = 2'b00; sg = 1'b0; ad = '0; wd = '0;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset d%0d resp_valid", s), f_rv(s),  0);
      chk($sformatf("reset d%0d resp_rdata", s), f_rd(s),  0);
      chk($sformatf("reset d%0d resp_err", s),   f_err(s), 0);
      chk($sformatf("reset d%0d req_ready", s),  f_rdy(s), 0);
    end
    reset = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) chk($sformatf("post-reset d%0d req_ready", s), f_rdy(s), 1);
    @(negedge clk);

    for (int i = 0; i < 26; i++) begin
      xact(1, tv[i].w, tv[i].z, tv[i].g, tv[i].a, tv[i].d, rd, er, lat);
      chk($sformatf("v%0d rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("v%0d err", i),   er, tv[i].exp_err);
      chk($sformatf("v%0d latency", i), lat, 3);
    end

    xact(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0BADF00D, rd, er, lat);
    chk("w0 store latency", lat, 2);
    xact(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat);
    chk("w0 load latency", lat, 2);
    chk("w0 load rdata", rd, 32'h0BADF00D);

    // Request held valid across a transaction on the zero-wait instance
    @(negedge clk);
    wr = 1'b1; sz = 2'b10; sg = 1'b0; ad = 32'h40; wd = 32'hA5A5A5A5; vld[0] = 1'b1;
    chk("held c0 ready", f_rdy(0), 1);
    @(posedge clk);
    #1 wr = 1'b0; wd = 32'h0;
    @(negedge clk);
    chk("held c1 ready", f_rdy(0), 0);
    chk("held c1 resp_valid", f_rv(0), 0);
    @(negedge clk);
    chk("held c2 ready", f_rdy(0), 0);
    chk("held c2 resp_valid", f_rv(0), 1);
    chk("held c2 err", f_err(0), 0);
    @(negedge clk);
    chk("held c3 ready", f_rdy(0), 1);
    chk("held c3 resp_valid", f_rv(0), 0);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    chk("held c4 resp_valid", f_rv(0), 0);
    @(negedge clk);
    chk("held c5 resp_valid", f_rv(0), 1);
    chk("held c5 rdata", f_rd(0), 32'hA5A5A5A5);

    xact(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'h13579BDF, rd, er, lat);
    chk("w15 store latency", lat, 17);
    xact(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("w15 load latency", lat, 17);
    chk("w15 load rdata", rd, 32'h13579BDF);

    // Abort a store with reset while it sits in WAIT
    wr = 1'b1; sz = 2'b10; sg = 1'b0; ad = 32'h20; wd = 32'h55AA55AA; vld[2] = 1'b1;
    lat = 0;
    while (!f_rdy(2) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!f_rdy(2)) fail_now("abort accept");
    @(posedge clk);
    #1 vld[2] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort ready in reset", f_rdy(2), 0);
    chk("abort resp_valid in reset", f_rv(2), 0);
    chk("abort rdata cleared", f_rd(2), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nrv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (f_rv(2)) nrv++;
    end
    chk("abort no resp_valid", nrv, 0);
    xact(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("abort prior value kept", rd, 32'h13579BDF);
    chk("abort load err", er, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
